// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle control unit.
// States, opcodes, ALUControl codes, ImmSrc codes and mux selects.
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECUTER,
      S_EXECUTEI,
      S_ALUWB,
      S_JAL,
      S_JALR1,
      S_JALR2,
      S_BRANCH,
      S_LUI
   } state_e;

   typedef enum logic [1:0] {
      AOP_ADD,
      AOP_SUB,
      AOP_FUNCT,
      AOP_PASSB
   } aluop_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;
   localparam logic [3:0] ALU_AND   = 4'b0010;
   localparam logic [3:0] ALU_OR    = 4'b0011;
   localparam logic [3:0] ALU_XOR   = 4'b0100;
   localparam logic [3:0] ALU_SLT   = 4'b0101;
   localparam logic [3:0] ALU_SLTU  = 4'b0110;
   localparam logic [3:0] ALU_SLL   = 4'b0111;
   localparam logic [3:0] ALU_SRL   = 4'b1000;
   localparam logic [3:0] ALU_SRA   = 4'b1001;
   localparam logic [3:0] ALU_PASSB = 4'b1010;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_A     = 2'b10;

   localparam logic [1:0] SRCB_WD    = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

endpackage

// File: rtl/control_unit_if.sv
// Instruction, ALU flags and datapath control lines of the control unit.
// master = control unit, slave = datapath.
interface control_unit_if;
   logic [31:0] Instr;
   logic        Zero;
   logic        CarryOut;
   logic        Overflow;
   logic        Sign;
   logic        PCWrite;
   logic        AdrSrc;
   logic        MemWrite;
   logic        IRWrite;
   logic        RegWrite;
   logic [1:0]  ResultSrc;
   logic [1:0]  ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic [3:0]  ALUControl;
   logic [2:0]  ImmSrc;
   logic        illegal_instr;

   modport master (
      input  Instr, Zero, CarryOut, Overflow, Sign,
      output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
      output ResultSrc, ALUSrcA, ALUSrcB, ALUControl,
      output ImmSrc, illegal_instr
   );

   modport slave (
      output Instr, Zero, CarryOut, Overflow, Sign,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
      input  ResultSrc, ALUSrcA, ALUSrcB, ALUControl,
      input  ImmSrc, illegal_instr
   );
endinterface

// File: rtl/alu_decoder.sv
// Maps ALU-op class, funct3, Instr[30] and opcode[5] to ALUControl.
module alu_decoder
   import ctrl_pkg::*;
(
   input  aluop_e     aluop_i,
   input  logic [2:0] funct3_i,
   input  logic       instr30_i,
   input  logic       op5_i,
   output logic [3:0] alu_ctrl_o
);

   logic [3:0] fn_ctrl;

   // Instr[30] means sub only on R-type; on shifts it means sra for both.
   always_comb begin
      fn_ctrl = ALU_ADD;
      case (funct3_i)
         3'b000:  fn_ctrl = (op5_i & instr30_i) ? ALU_SUB : ALU_ADD;
         3'b001:  fn_ctrl = ALU_SLL;
         3'b010:  fn_ctrl = ALU_SLT;
         3'b011:  fn_ctrl = ALU_SLTU;
         3'b100:  fn_ctrl = ALU_XOR;
         3'b101:  fn_ctrl = instr30_i ? ALU_SRA : ALU_SRL;
         3'b110:  fn_ctrl = ALU_OR;
         default: fn_ctrl = ALU_AND;
      endcase
   end

   always_comb begin
      alu_ctrl_o = ALU_ADD;
      case (aluop_i)
         AOP_SUB:   alu_ctrl_o = ALU_SUB;
         AOP_FUNCT: alu_ctrl_o = fn_ctrl;
         AOP_PASSB: alu_ctrl_o = ALU_PASSB;
         default:   alu_ctrl_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Multicycle RV32I control FSM: Moore outputs per state,
// write enables forced low while rst_n is asserted.
module control_unit
   import ctrl_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   control_unit_if.master bus
);

   state_e     state_q, state_d;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       is_load, is_store, is_op, is_imm, is_jal;
   logic       is_jalr, is_branch, is_lui, is_auipc;
   logic       known, illegal, br_take, lt;
   logic       pcw, adr, mw, irw, rw, ill;
   logic [1:0] rs, sa, sb;
   logic [2:0] imm_src;
   aluop_e     aop;
   logic [3:0] alu_ctrl;
   logic       unused;

   assign opcode = bus.Instr[6:0];
   assign funct3 = bus.Instr[14:12];
   assign unused = ^{bus.Instr[31], bus.Instr[29:15], bus.Instr[11:7]};

   assign is_load   = (opcode == OP_LOAD);
   assign is_store  = (opcode == OP_STORE);
   assign is_op     = (opcode == OP_OP);
   assign is_imm    = (opcode == OP_IMM);
   assign is_jal    = (opcode == OP_JAL);
   assign is_jalr   = (opcode == OP_JALR);
   assign is_branch = (opcode == OP_BRANCH);
   assign is_lui    = (opcode == OP_LUI);
   assign is_auipc  = (opcode == OP_AUIPC);

   assign known = is_load | is_store | is_op | is_imm | is_jal
                | is_jalr | is_branch | is_lui | is_auipc;

   assign illegal = !known
                  | ((is_load | is_store) & (funct3 != 3'b010))
                  | (is_branch & (funct3[2:1] == 2'b01));

   always_comb begin
      imm_src = IMM_I;
      unique case (1'b1)
         is_load, is_jalr, is_imm: imm_src = IMM_I;
         is_store:                 imm_src = IMM_S;
         is_branch:                imm_src = IMM_B;
         is_jal:                   imm_src = IMM_J;
         is_lui, is_auipc:         imm_src = IMM_U;
         default:                  imm_src = IMM_I;
      endcase
   end

   // CarryOut=1 means no borrow, so unsigned less-than is !CarryOut.
   assign lt = bus.Sign ^ bus.Overflow;
   always_comb begin
      br_take = 1'b0;
      case (funct3)
         3'b000:  br_take = bus.Zero;
         3'b001:  br_take = !bus.Zero;
         3'b100:  br_take = lt;
         3'b101:  br_take = !lt;
         3'b110:  br_take = !bus.CarryOut;
         3'b111:  br_take = bus.CarryOut;
         default: br_take = 1'b0;
      endcase
   end

   always_comb begin
      state_d = S_FETCH;
      unique case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            state_d = S_FETCH;
            if (!illegal) begin
               unique case (1'b1)
                  is_load, is_store: state_d = S_MEMADR;
                  is_op:             state_d = S_EXECUTER;
                  is_imm:            state_d = S_EXECUTEI;
                  is_jal:            state_d = S_JAL;
                  is_jalr:           state_d = S_JALR1;
                  is_branch:         state_d = S_BRANCH;
                  is_lui:            state_d = S_LUI;
                  is_auipc:          state_d = S_ALUWB;
                  default:           state_d = S_FETCH;
               endcase
            end
         end
         S_MEMADR:   state_d = is_load ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = S_MEMWB;
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         S_JAL:      state_d = S_ALUWB;
         S_JALR1:    state_d = S_JALR2;
         S_JALR2:    state_d = S_ALUWB;
         S_LUI:      state_d = S_ALUWB;
         default:    state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      pcw = 1'b0;
      adr = 1'b0;
      mw  = 1'b0;
      irw = 1'b0;
      rw  = 1'b0;
      ill = 1'b0;
      rs  = RES_ALUOUT;
      sa  = SRCA_PC;
      sb  = SRCB_WD;
      aop = AOP_ADD;
      unique case (state_q)
         S_FETCH: begin
            irw = 1'b1;
            pcw = 1'b1;
            rs  = RES_ALURES;
            sb  = SRCB_FOUR;
         end
         S_DECODE: begin
            sa  = SRCA_OLDPC;
            sb  = SRCB_IMM;
            ill = illegal;
         end
         S_MEMADR: begin
            sa = SRCA_A;
            sb = SRCB_IMM;
         end
         S_MEMREAD: adr = 1'b1;
         S_MEMWB: begin
            rs = RES_DATA;
            rw = 1'b1;
         end
         S_MEMWRITE: begin
            adr = 1'b1;
            mw  = 1'b1;
         end
         S_EXECUTER: begin
            sa  = SRCA_A;
            aop = AOP_FUNCT;
         end
         S_EXECUTEI: begin
            sa  = SRCA_A;
            sb  = SRCB_IMM;
            aop = AOP_FUNCT;
         end
         S_ALUWB: rw = 1'b1;
         // PC takes the OldPC+imm target while ALU forms OldPC+4 for rd.
         S_JAL, S_JALR2: begin
            pcw = 1'b1;
            sa  = SRCA_OLDPC;
            sb  = SRCB_FOUR;
         end
         S_JALR1: begin
            sa = SRCA_A;
            sb = SRCB_IMM;
         end
         S_BRANCH: begin
            sa  = SRCA_A;
            aop = AOP_SUB;
            pcw = br_take;
         end
         S_LUI: begin
            sb  = SRCB_IMM;
            aop = AOP_PASSB;
         end
         default: ;
      endcase
   end

   alu_decoder u_alu_dec (
      .aluop_i   (aop),
      .funct3_i  (funct3),
      .instr30_i (bus.Instr[30]),
      .op5_i     (bus.Instr[5]),
      .alu_ctrl_o(alu_ctrl)
   );

   assign bus.PCWrite       = pcw & rst_n;
   assign bus.AdrSrc        = adr;
   assign bus.MemWrite      = mw & rst_n;
   assign bus.IRWrite       = irw & rst_n;
   assign bus.RegWrite      = rw & rst_n;
   assign bus.illegal_instr = ill & rst_n;
   assign bus.ResultSrc     = rs;
   assign bus.ALUSrcA       = sa;
   assign bus.ALUSrcB       = sb;
   assign bus.ALUControl    = alu_ctrl;
   assign bus.ImmSrc        = imm_src;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed instructions plus random ones,
// checked per cycle against a per-instruction step model.
module tb_control_unit;

   typedef struct packed {
      logic       pcw;
      logic       adr;
      logic       mw;
      logic       irw;
      logic       rw;
      logic [1:0] rs;
      logic [1:0] sa;
      logic [1:0] sb;
      logic [3:0] alu;
      logic [2:0] imm;
      logic       ill;
   } outs_t;

   localparam int K_FETCH = 0, K_DECODE = 1, K_MEMADR = 2;
   localparam int K_MEMREAD = 3, K_MEMWB = 4, K_MEMWRITE = 5;
   localparam int K_EXR = 6, K_EXI = 7, K_ALUWB = 8, K_JAL = 9;
   localparam int K_JALR1 = 10, K_JALR2 = 11, K_BRANCH = 12;
   localparam int K_LUI = 13;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   seq_q[$];

   control_unit_if bus();

   control_unit dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #10 clk = ~clk;

   function automatic logic [2:0] imm_of(logic [6:0] op);
      case (op)
         7'h03, 7'h67, 7'h13: return 3'd0;
         7'h23:               return 3'd1;
         7'h63:               return 3'd2;
         7'h6F:               return 3'd3;
         7'h37, 7'h17:        return 3'd4;
         default:             return 3'd0;
      endcase
   endfunction

   function automatic bit bad(logic [31:0] i);
      logic [6:0] op;
      logic [2:0] f3;
      op = i[6:0];
      f3 = i[14:12];
      if (!(op inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h6F,
                       7'h67, 7'h63, 7'h37, 7'h17}))
         return 1'b1;
      if ((op == 7'h03 || op == 7'h23) && f3 != 3'd2)
         return 1'b1;
      if (op == 7'h63 && (f3 == 3'd2 || f3 == 3'd3))
         return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [3:0] alu_of(logic [31:0] i, bit rtype);
      case (i[14:12])
         3'd0: return (rtype && i[30]) ? 4'd1 : 4'd0;
         3'd1: return 4'd7;
         3'd2: return 4'd5;
         3'd3: return 4'd6;
         3'd4: return 4'd4;
         3'd5: return i[30] ? 4'd9 : 4'd8;
         3'd6: return 4'd3;
         default: return 4'd2;
      endcase
   endfunction

   // flags = {Zero, CarryOut, Overflow, Sign}
   function automatic logic taken(logic [2:0] f3, logic [3:0] fl);
      logic z, c, v, s;
      {z, c, v, s} = fl;
      case (f3)
         3'd0: return z;
         3'd1: return !z;
         3'd4: return s != v;
         3'd5: return s == v;
         3'd6: return !c;
         3'd7: return c;
         default: return 1'b0;
      endcase
   endfunction

   function automatic outs_t step_out(int k, logic [31:0] i,
                                     logic [3:0] fl);
      outs_t o;
      o = '0;
      o.imm = imm_of(i[6:0]);
      case (k)
         K_FETCH: begin
            o.pcw = 1; o.irw = 1; o.rs = 2; o.sb = 2;
         end
         K_DECODE:   begin o.sa = 1; o.sb = 1; o.ill = bad(i); end
         K_MEMADR:   begin o.sa = 2; o.sb = 1; end
         K_MEMREAD:  o.adr = 1;
         K_MEMWB:    begin o.rs = 1; o.rw = 1; end
         K_MEMWRITE: begin o.adr = 1; o.mw = 1; end
         K_EXR:      begin o.sa = 2; o.alu = alu_of(i, 1); end
         K_EXI: begin
            o.sa = 2; o.sb = 1; o.alu = alu_of(i, 0);
         end
         K_ALUWB:    o.rw = 1;
         K_JAL, K_JALR2: begin o.pcw = 1; o.sa = 1; o.sb = 2; end
         K_JALR1:    begin o.sa = 2; o.sb = 1; end
         K_BRANCH: begin
            o.sa = 2; o.alu = 1; o.pcw = taken(i[14:12], fl);
         end
         K_LUI:      begin o.sb = 1; o.alu = 4'd10; end
         default: ;
      endcase
      return o;
   endfunction

   task automatic build_seq(input logic [31:0] i);
      seq_q.delete();
      seq_q.push_back(K_FETCH);
      seq_q.push_back(K_DECODE);
      if (!bad(i)) begin
         case (i[6:0])
            7'h03: seq_q = {seq_q, K_MEMADR, K_MEMREAD, K_MEMWB};
            7'h23: seq_q = {seq_q, K_MEMADR, K_MEMWRITE};
            7'h33: seq_q = {seq_q, K_EXR, K_ALUWB};
            7'h13: seq_q = {seq_q, K_EXI, K_ALUWB};
            7'h6F: seq_q = {seq_q, K_JAL, K_ALUWB};
            7'h67: seq_q = {seq_q, K_JALR1, K_JALR2, K_ALUWB};
            7'h63: seq_q.push_back(K_BRANCH);
            7'h37: seq_q = {seq_q, K_LUI, K_ALUWB};
            default: seq_q.push_back(K_ALUWB);
         endcase
      end
   endtask

   function automatic outs_t observed();
      outs_t o;
      o.pcw = bus.PCWrite;
      o.adr = bus.AdrSrc;
      o.mw  = bus.MemWrite;
      o.irw = bus.IRWrite;
      o.rw  = bus.RegWrite;
      o.rs  = bus.ResultSrc;
      o.sa  = bus.ALUSrcA;
      o.sb  = bus.ALUSrcB;
      o.alu = bus.ALUControl;
      o.imm = bus.ImmSrc;
      o.ill = bus.illegal_instr;
      return o;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_en_low(input string tag);
      chk(tag, {27'd0, bus.PCWrite, bus.IRWrite, bus.RegWrite,
                bus.MemWrite, bus.illegal_instr}, 32'd0);
   endtask

   // Entered and left at negedge+1 of the cycle whose step is checked.
   task automatic run_steps(input string nm, input logic [31:0] i,
                            input int nmax, input bit fix,
                            input logic [3:0] ffl);
      logic [3:0] fl;
      build_seq(i);
      for (int s = 0; s < seq_q.size() && s < nmax; s++) begin
         fl = fix ? ffl : 4'($urandom);
         bus.Instr = i;
         {bus.Zero, bus.CarryOut, bus.Overflow, bus.Sign} = fl;
         #1;
         chk($sformatf("%s c%0d", nm, s + 1), 32'(observed()),
             32'(step_out(seq_q[s], i, fl)));
         @(negedge clk);
         #1;
      end
   endtask

   task automatic run_instr(input string nm, input logic [31:0] i);
      run_steps(nm, i, 99, 1'b0, 4'd0);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [6:0] ops [12];
      logic [31:0] i;
      int sel;
      ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h6F, 7'h67,
              7'h63, 7'h37, 7'h17, 7'h7F, 7'h0B, 7'h00};
      sel = $urandom_range(0, 11);
      i = $urandom;
      i[6:0] = ops[sel];
      if (sel < 2 && $urandom_range(0, 3) != 0) i[14:12] = 3'd2;
      return i;
   endfunction

   initial begin
      logic [3:0] fl;
      bus.Instr = 32'd0;
      {bus.Zero, bus.CarryOut, bus.Overflow, bus.Sign} = 4'd0;
      repeat (2) @(negedge clk);
      #1;
      chk_en_low("reset_en");
      rst_n = 1'b1;

      run_instr("lw", 32'h0080A283);
      run_instr("sw", 32'h0020A223);
      run_instr("sub", 32'h402081B3);
      run_instr("addi_b30", 32'h40008093);
      run_instr("srai", 32'h4050D093);
      run_instr("sra", 32'h4020D1B3);
      run_steps("blt_t", 32'h0020C463, 99, 1'b1, 4'b0001);
      run_steps("blt_n", 32'h0020C463, 99, 1'b1, 4'b0011);
      run_steps("bltu_t", 32'h0020E463, 99, 1'b1, 4'b0000);
      run_steps("beq_t", 32'h00208463, 99, 1'b1, 4'b1000);
      run_instr("jalr", 32'h000080E7);
      run_instr("jal", 32'h008000EF);
      run_instr("lui", 32'h123450B7);
      run_instr("auipc", 32'h12345097);
      run_instr("ill7f", 32'h0000007F);
      run_instr("ill_lw", 32'h0000B283);
      run_instr("ill_br", 32'h0020A463);

      // Abort a store in MEMWRITE with an asynchronous reset.
      run_steps("sw_ab", 32'h0020A223, 3, 1'b0, 4'd0);
      fl = 4'($urandom);
      {bus.Zero, bus.CarryOut, bus.Overflow, bus.Sign} = fl;
      #1;
      chk("sw_ab c4", 32'(observed()),
          32'(step_out(K_MEMWRITE, 32'h0020A223, fl)));
      #2 rst_n = 1'b0;
      #1;
      chk_en_low("abort_now");
      @(negedge clk);
      #1;
      chk_en_low("abort_hold");
      rst_n = 1'b1;
      run_instr("post_rst", 32'h00208463);

      for (int n = 0; n < 200; n++)
         run_instr($sformatf("rnd%0d", n), rand_instr());

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock.
REQ-002 SHALL have: rst_n input 1, asynchronous active-low reset.
REQ-003 SHALL have: Instr input 32, fetched instruction from the instruction register.
REQ-004 SHALL have: Zero, CarryOut, Overflow, Sign inputs 1 each, ALU flags for the current-cycle ALUResult; CarryOut=1 means no borrow on subtract.
REQ-005 SHALL have these outputs, 1 bit each: PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite.
REQ-006 SHALL have: ResultSrc output 2; 00=ALUOut, 01=Data, 10=ALUResult.
REQ-007 SHALL have: ALUSrcA output 2; 00=PC, 01=OldPC, 10=A.
REQ-008 SHALL have: ALUSrcB output 2; 00=WriteData, 01=ImmExt, 10=constant 4.
REQ-009 SHALL have: ALUControl output 4; add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sltu 0110, sll 0111, srl 1000, sra 1001, passB 1010.
REQ-010 SHALL have: ImmSrc output 3; I 000, S 001, B 010, J 011, U 100.
REQ-011 SHALL have: illegal_instr output 1, a one-cycle pulse on an unsupported encoding.

Function
REQ-012 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, JAL, JALR1, JALR2, BRANCH, LUI.
REQ-013 SHALL decode ImmSrc combinationally from Instr[6:0] only, independent of state: load/jalr/op-imm=I, store=S, branch=B, jal=J, lui/auipc=U.
REQ-014 FETCH SHALL assert AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10, PCWrite=1, then go to DECODE.
REQ-015 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01 with add, so ALUOut=OldPC+imm.
REQ-015a DECODE SHALL branch on opcode: load/store→MEMADR, op→EXECUTER, op-imm→EXECUTEI, jal→JAL, jalr→JALR1, branch→BRANCH, lui→LUI, auipc→ALUWB.
REQ-016 MEMADR SHALL drive A+imm with add, then go to MEMREAD for a load or MEMWRITE for a store.
REQ-016a MEMREAD SHALL drive AdrSrc=1, ResultSrc=00, then go to MEMWB.
REQ-016b MEMWB SHALL drive ResultSrc=01, RegWrite=1, then go to FETCH.
REQ-016c MEMWRITE SHALL drive AdrSrc=1, ResultSrc=00, MemWrite=1, then go to FETCH.
REQ-017 EXECUTER SHALL drive A op WriteData, and EXECUTEI SHALL drive A op imm; both go to ALUWB, where ALUControl comes from funct3 and Instr[30].
REQ-017a Instr[30] SHALL select sub only for R-type; it SHALL select sra/srai on both R-type and I-type.
REQ-018 ALUWB SHALL drive ResultSrc=00, RegWrite=1, then go to FETCH.
REQ-018a JAL SHALL drive PCWrite=1, ResultSrc=00, ALUSrcA=01, ALUSrcB=10 with add, then go to ALUWB, so rd=OldPC+4.
REQ-019 JALR1 SHALL drive A+imm.
REQ-019a JALR2 SHALL drive PCWrite=1, ResultSrc=00, OldPC+4 with add, then go to ALUWB.
REQ-020 LUI SHALL drive ALUSrcB=01 with passB, then go to ALUWB.
REQ-021 BRANCH SHALL drive A−WriteData with sub, ResultSrc=00, then go to FETCH.
REQ-021a BRANCH SHALL drive PCWrite = condition: beq Zero, bne !Zero, blt Sign^Overflow, bge !(Sign^Overflow), bltu !CarryOut, bgeu CarryOut.
REQ-022 Cycle counts SHALL be exactly: load 5, store 4, R/I 4, jal 4, jalr 5, lui 4, auipc 3, branch 3.
REQ-023 Illegal encodings SHALL be: unknown opcode; load/store funct3≠010; branch funct3 010/011.
REQ-023a On an illegal encoding, DECODE SHALL pulse illegal_instr, assert no write enable, and return to FETCH.
REQ-024 In every state, write enables not listed for that state SHALL be 0, and unlisted selects SHALL be 00.

Reset
REQ-025 rst_n low SHALL force state=FETCH asynchronously and hold PCWrite, IRWrite, RegWrite, MemWrite and illegal_instr at 0 while asserted.
REQ-026 The first clk edge after rst_n rises SHALL execute FETCH.
REQ-027 Reset asserted mid-instruction SHALL abort that instruction with no further register, memory or PC write.

Structure
REQ-028 A shared package ctrl_pkg SHALL hold the state enum, opcode constants, ALUControl codes, ImmSrc codes and mux select codes.
REQ-029 A sub-module alu_decoder SHALL map (ALU-op class, funct3, Instr[30], opcode[5]) to ALUControl.

Verification
REQ-030 Reset then lw x5,8(x1) → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in cycle 5 with ResultSrc=01.
REQ-031 sw x2,4(x1) → MemWrite=1 only in cycle 4 with AdrSrc=1; RegWrite never asserted.
REQ-032 sub x3,x1,x2 (Instr[30]=1) → ALUControl=0001 in EXECUTER; addi with Instr[30]=1 → 0000.
REQ-033 blt with Sign=1, Overflow=0 → PCWrite=1 in cycle 3; with Sign=1, Overflow=1 → PCWrite=0.
REQ-034 jalr → PCWrite=1 in cycle 4 (JALR2) and RegWrite=1 in cycle 5; opcode 0x7F → illegal_instr=1 in DECODE, then FETCH.
REQ-035 rst_n dropped during MEMWRITE → MemWrite=0 immediately; after release, FETCH executes.
